// File: rtl/sram_cfg_pkg.sv
// Shared state encoding and lane helpers for the SRAM config loader.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package sram_cfg_pkg;

    typedef enum logic [2:0] {
        ST_LOAD     = 3'd0,
        ST_RUN      = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4
    } cfg_state_e;

    // Pick the byte lane addressed by byte-address bit 20.
    function automatic logic [7:0] lane_sel(input logic [15:0] word, input logic upper);
        return upper ? word[15:8] : word[7:0];
    endfunction

    // Byte writes put the same byte on both lanes; the lane enables decide which lands.
    function automatic logic [15:0] rep_byte(input logic [7:0] b);
        return {b, b};
    endfunction

endpackage

// File: rtl/sram_lane_mux.sv
// Maps a byte address/strobe set onto the 16-bit SRAM: word address, lane enables, tristate.
// Latency: purely combinational.
// Backpressure: none; the SRAM is assumed to complete within the caller's access window.
// Ports: addr/we_n/oe_n/drv/wr_dat from the current bus owner; rd_dat = selected lane
//        (or wr_dat echoed while writing); sram_* go straight to the chip pins.
module sram_lane_mux
    import sram_cfg_pkg::*;
(
    input  logic [20:0] addr,
    input  logic        we_n,
    input  logic        oe_n,
    input  logic        drv,
    input  logic [7:0]  wr_dat,
    output logic [7:0]  rd_dat,
    output logic [19:0] sram_addr,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n,
    inout  wire  [15:0] sram_data
);

    assign sram_addr = addr[19:0];
    assign sram_we_n = we_n;
    assign sram_oe_n = oe_n;
    assign sram_ub_n = ~addr[20];
    assign sram_lb_n = addr[20];

    assign sram_data = drv ? rep_byte(wr_dat) : 16'hzzzz;

    assign rd_dat = !we_n ? wr_dat : lane_sel(sram_data, addr[20]);

endmodule

// File: rtl/sram_config_loader.sv
// Loads a small config image from SRAM after reset, then passes the host through and saves on request.
// Latency: load CFG_BYTES*(WAIT_CYCLES+1) cycles after reset release; save CFG_BYTES*(WAIT_CYCLES+3).
// Backpressure: busy=1 while the block owns the SRAM; host strobes/cfg writes are dropped, saves are queued.
// Ports: clk/rst_n; sram_*_in/sram_data_to_chip/sram_data_from_chip = host side;
//        sram_*_out/sram_data = chip side; pwon_reset/busy = status; cfg_wr_*/save_req/save_done = image
//        update and write-back; cfg_out/vga_on/scanlines_off = image outputs.
module sram_config_loader
    import sram_cfg_pkg::*;
#(
    parameter int                     CFG_BYTES   = 2,
    parameter logic [20:0]            CFG_BASE    = 21'h008FD5,
    parameter int                     WAIT_CYCLES = 1,
    parameter logic [CFG_BYTES*8-1:0] CFG_DEFAULT = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [20:0]            sram_addr_in,
    input  logic                   sram_we_n_in,
    input  logic                   sram_oe_n_in,
    input  logic [7:0]             sram_data_to_chip,
    output logic [7:0]             sram_data_from_chip,
    output logic [19:0]            sram_addr_out,
    output logic                   sram_we_n_out,
    output logic                   sram_oe_n_out,
    output logic                   sram_ub_n_out,
    output logic                   sram_lb_n_out,
    inout  wire  [15:0]            sram_data,
    output logic                   pwon_reset,
    output logic                   busy,
    input  logic                   cfg_wr_en,
    input  logic [3:0]             cfg_wr_idx,
    input  logic [7:0]             cfg_wr_data,
    input  logic                   save_req,
    output logic                   save_done,
    output logic [CFG_BYTES*8-1:0] cfg_out,
    output logic                   vga_on,
    output logic                   scanlines_off
);

    localparam logic [3:0] LAST_IDX  = 4'(CFG_BYTES - 1);
    localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES);

    cfg_state_e             state;
    logic [3:0]             idx;
    logic [3:0]             wcnt;
    logic [CFG_BYTES*8-1:0] cfg_q;
    logic                   pwon_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   save_pend;

    // Block-owned access, decoded from state so reset releases the bus at once.
    logic [7:0]  cur_byte;
    logic [20:0] own_addr;
    logic        own_we_n;
    logic        own_oe_n;
    logic        own_drv;

    logic [20:0] mux_addr;
    logic        mux_we_n;
    logic        mux_oe_n;
    logic        mux_drv;
    logic [7:0]  mux_wdat;
    logic [7:0]  mux_rdat;

    always_comb begin
        cur_byte = 8'h00;
        for (int b = 0; b < CFG_BYTES; b++) begin
            if (idx == 4'(b)) cur_byte = cfg_q[b*8 +: 8];
        end
    end

    assign own_addr = CFG_BASE + {17'd0, idx};
    // Reset holds state at LOAD; gate OE so the chip stays quiet until release.
    assign own_oe_n = !((state == ST_LOAD) && rst_n);
    assign own_we_n = (state != ST_WR_PULSE);
    assign own_drv  = (state == ST_WR_SETUP) || (state == ST_WR_PULSE) || (state == ST_WR_HOLD);

    // Host sees the pins only while the block is idle.
    assign mux_addr = busy_q ? own_addr : sram_addr_in;
    assign mux_we_n = busy_q ? own_we_n : sram_we_n_in;
    assign mux_oe_n = busy_q ? own_oe_n : sram_oe_n_in;
    assign mux_drv  = busy_q ? own_drv  : ~sram_we_n_in;
    assign mux_wdat = busy_q ? cur_byte : sram_data_to_chip;

    sram_lane_mux u_lane_mux (
        .addr      (mux_addr),
        .we_n      (mux_we_n),
        .oe_n      (mux_oe_n),
        .drv       (mux_drv),
        .wr_dat    (mux_wdat),
        .rd_dat    (mux_rdat),
        .sram_addr (sram_addr_out),
        .sram_we_n (sram_we_n_out),
        .sram_oe_n (sram_oe_n_out),
        .sram_ub_n (sram_ub_n_out),
        .sram_lb_n (sram_lb_n_out),
        .sram_data (sram_data)
    );

    assign sram_data_from_chip = busy_q ? 8'hFF : mux_rdat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_LOAD;
            idx       <= 4'd0;
            wcnt      <= 4'd0;
            cfg_q     <= CFG_DEFAULT;
            pwon_q    <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            save_pend <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Requests arriving while busy collapse into one pending save.
            if (save_req && (state != ST_RUN)) save_pend <= 1'b1;

            case (state)
                ST_LOAD: begin
                    if (wcnt == LAST_WAIT) begin
                        wcnt <= 4'd0;
                        for (int b = 0; b < CFG_BYTES; b++) begin
                            if (idx == 4'(b)) cfg_q[b*8 +: 8] <= mux_rdat;
                        end
                        if (idx == LAST_IDX) begin
                            idx    <= 4'd0;
                            state  <= ST_RUN;
                            pwon_q <= 1'b0;
                            busy_q <= 1'b0;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                ST_RUN: begin
                    // Out-of-range indices match no byte and fall through untouched.
                    if (cfg_wr_en) begin
                        for (int b = 0; b < CFG_BYTES; b++) begin
                            if (cfg_wr_idx == 4'(b)) cfg_q[b*8 +: 8] <= cfg_wr_data;
                        end
                    end
                    if (save_req || save_pend) begin
                        save_pend <= 1'b0;
                        busy_q    <= 1'b1;
                        idx       <= 4'd0;
                        wcnt      <= 4'd0;
                        state     <= ST_WR_SETUP;
                    end
                end
                ST_WR_SETUP: begin
                    wcnt  <= 4'd0;
                    state <= ST_WR_PULSE;
                end
                ST_WR_PULSE: begin
                    if (wcnt == LAST_WAIT) begin
                        wcnt  <= 4'd0;
                        state <= ST_WR_HOLD;
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                ST_WR_HOLD: begin
                    if (idx == LAST_IDX) begin
                        idx    <= 4'd0;
                        state  <= ST_RUN;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        idx   <= idx + 4'd1;
                        state <= ST_WR_SETUP;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    assign pwon_reset    = pwon_q;
    assign busy          = busy_q;
    assign save_done     = done_q;
    assign cfg_out       = cfg_q;
    assign vga_on        = cfg_q[0];
    assign scanlines_off = ~cfg_q[1];

endmodule
